// File: rtl/snn_pkg.sv
// Shared definitions for the spike encoder: parameter defaults, FSM states and LFSR constants.
package snn_pkg;

    localparam int N_PIX_DEF  = 16;
    localparam int PIX_W_DEF  = 8;
    localparam int STEP_W_DEF = 8;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } enc_state_t;

    // A shift by 16 yields zero, so s == 0 returns v unchanged.
    function automatic logic [15:0] rotl16(input logic [15:0] v, input logic [3:0] s);
        return (v << s) | (v >> (5'd16 - {1'b0, s}));
    endfunction

endpackage

// File: rtl/enc_lfsr.sv
// 16-bit Galois LFSR for stochastic spike thresholds; reseeded on reset or load, steps on advance.
module enc_lfsr
    import snn_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_advance,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_advance) begin
            r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_POLY) : (r_lfsr >> 1);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/spike_encoder.sv
// Frame-to-spike encoder with valid/ready output; default is accumulator rate coding.
// Define SPIKE_ENC_LFSR_EN to switch to stochastic LFSR-threshold coding.
module spike_encoder
    import snn_pkg::*;
#(
    parameter int N_PIX  = N_PIX_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_PIX*PIX_W-1:0] pix_in,
    input  logic [STEP_W-1:0]      num_steps,
    output logic [N_PIX-1:0]       spike_out,
    output logic                   spike_valid,
    input  logic                   spike_ready,
    output logic                   busy,
    output logic                   done
);

    enc_state_t        r_state;
    enc_state_t        w_state_nxt;
    logic [STEP_W-1:0] r_num_steps;
    logic [STEP_W-1:0] r_step;
    logic [PIX_W-1:0]  r_pix [N_PIX];
    logic [N_PIX-1:0]  w_spike;
    logic              w_hs;
    logic              w_last;

    assign w_hs   = (r_state == RUN) && spike_ready;
    assign w_last = (r_step == r_num_steps - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        w_state_nxt = r_state;
        spike_valid = 1'b0;
        spike_out   = '0;
        busy        = (r_state != IDLE);
        done        = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_nxt = LOAD;
            LOAD: w_state_nxt = (r_num_steps == '0) ? DONE : RUN;
            RUN: begin
                spike_valid = 1'b1;
                spike_out   = w_spike;
                if (w_hs && w_last) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The step counter stops at num_steps, which always fits in STEP_W bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_steps <= '0;
            r_step      <= '0;
            for (int i = 0; i < N_PIX; i++) r_pix[i] <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_num_steps <= num_steps;
                for (int i = 0; i < N_PIX; i++) r_pix[i] <= pix_in[i*PIX_W +: PIX_W];
            end
            if (r_state == LOAD) begin
                r_step <= '0;
            end else if (w_hs) begin
                r_step <= r_step + 1'b1;
            end
        end
    end

`ifdef SPIKE_ENC_LFSR_EN
    localparam logic [15:0] THR_MASK = 16'((17'd1 << PIX_W) - 17'd1);

    logic [15:0] w_lfsr;

    enc_lfsr u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .i_load    (r_state == LOAD),
        .i_advance (w_hs),
        .o_lfsr    (w_lfsr)
    );

    for (genvar g = 0; g < N_PIX; g++) begin : g_lane
        logic [15:0] w_rot;
        assign w_rot      = rotl16(w_lfsr, 4'(g));
        assign w_spike[g] = 16'(r_pix[g]) > (w_rot & THR_MASK);
    end
`else
    logic [PIX_W-1:0] r_acc     [N_PIX];
    logic [PIX_W-1:0] w_acc_nxt [N_PIX];

    // Carry out of acc + pix is the spike; the wrapped sum is the residue carried forward.
    for (genvar g = 0; g < N_PIX; g++) begin : g_lane
        logic [PIX_W:0] w_sum;
        assign w_sum        = {1'b0, r_acc[g]} + {1'b0, r_pix[g]};
        assign w_spike[g]   = w_sum[PIX_W];
        assign w_acc_nxt[g] = w_sum[PIX_W-1:0];
    end

    always_ff @(posedge clk) begin
        // NOTE: the accumulator array is real state that seeds the next spike, so it is reset explicitly.
        if (rst || r_state == LOAD) begin
            for (int i = 0; i < N_PIX; i++) r_acc[i] <= '0;
        end else if (w_hs) begin
            for (int i = 0; i < N_PIX; i++) r_acc[i] <= w_acc_nxt[i];
        end
    end
`endif

endmodule

// File: tb/tb_spike_encoder.sv
// Self-checking bench for spike_encoder: table-driven frames plus reset and backpressure sequences.
module tb_spike_encoder;
    import snn_pkg::*;

    localparam int NP = 16;
    localparam int PW = 8;
    localparam int SW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [NP*PW-1:0] pix_in = '0;
    logic [SW-1:0]  num_steps = '0;
    logic [NP-1:0]  spike_out;
    logic           spike_valid;
    logic           spike_ready = 1'b1;
    logic           busy;
    logic           done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    spike_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pix_in      (pix_in),
        .num_steps   (num_steps),
        .spike_out   (spike_out),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        logic [7:0]       pix0;
        logic [7:0]       pix_rest;
        int               steps;
        logic [7:0][15:0] exp;
    } frame_t;

    frame_t frames [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0][15:0] mk(input logic [15:0] e0, input logic [15:0] e1,
                                            input logic [15:0] e2, input logic [15:0] e3,
                                            input logic [15:0] e4, input logic [15:0] e5,
                                            input logic [15:0] e6, input logic [15:0] e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    function automatic logic [NP*PW-1:0] make_pix(input logic [7:0] p0, input logic [7:0] pr);
        logic [NP*PW-1:0] v;
        for (int i = 0; i < NP; i++) v[i*PW +: PW] = (i == 0) ? p0 : pr;
        return v;
    endfunction

    // Presents a start for one cycle; returns in the LOAD cycle.
    task automatic launch(input logic [7:0] p0, input logic [7:0] pr, input int steps);
        pix_in    = make_pix(p0, pr);
        num_steps = SW'(steps);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        pix_in    = '0;
        num_steps = '0;
    endtask

    task automatic run_frame(input int idx);
        frame_t f;
        f = frames[idx];
        launch(f.pix0, f.pix_rest, f.steps);
        check($sformatf("f%0d load valid", idx), 32'(spike_valid), 0);
        check($sformatf("f%0d load busy", idx), 32'(busy), 1);
        tick();
        for (int k = 0; k < f.steps; k++) begin
            check($sformatf("f%0d step%0d valid", idx, k + 1), 32'(spike_valid), 1);
            check($sformatf("f%0d step%0d spikes", idx, k + 1), 32'(spike_out), 32'(f.exp[k]));
            tick();
        end
        check($sformatf("f%0d done pulse", idx), 32'(done), 1);
        check($sformatf("f%0d done valid", idx), 32'(spike_valid), 0);
        check($sformatf("f%0d done spikes", idx), 32'(spike_out), 0);
        tick();
        check($sformatf("f%0d idle done", idx), 32'(done), 0);
        check($sformatf("f%0d idle busy", idx), 32'(busy), 0);
    endtask

`ifdef SPIKE_ENC_LFSR_EN
    logic [15:0] rec [2][16];

    task automatic lfsr_frame(input logic [7:0] p, input int slot);
        launch(p, p, 16);
        tick();
        for (int k = 0; k < 16; k++) begin
            check($sformatf("lfsr s%0d step%0d valid", slot, k + 1), 32'(spike_valid), 1);
            rec[slot][k] = spike_out;
            tick();
        end
        check($sformatf("lfsr s%0d done", slot), 32'(done), 1);
        tick();
    endtask
`endif

    initial begin
        frames[0] = '{8'd128, 8'd128, 4, mk(16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 0, 0, 0)};
        frames[1] = '{8'd255, 8'd0,   8, mk(16'h0000, 16'h0001, 16'h0001, 16'h0001,
                                            16'h0001, 16'h0001, 16'h0001, 16'h0001)};
        frames[2] = '{8'd64,  8'd64,  5, mk(16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 0, 0, 0)};
        frames[3] = '{8'd0,   8'd200, 3, mk(16'h0000, 16'hFFFE, 16'hFFFE, 0, 0, 0, 0, 0)};
        frames[4] = '{8'd255, 8'd255, 1, mk(16'h0000, 0, 0, 0, 0, 0, 0, 0)};
        frames[5] = '{8'd1,   8'd0,   0, mk(0, 0, 0, 0, 0, 0, 0, 0)};
        frames[6] = '{8'd100, 8'd60,  6, mk(16'h0000, 16'h0000, 16'h0001, 16'h0000,
                                            16'hFFFE, 16'h0001, 0, 0)};

        // Reset held with a coincident start: the start must not be taken.
        start = 1'b1;
        pix_in = make_pix(8'd255, 8'd255);
        num_steps = SW'(4);
        tick();
        tick();
        check("reset spike_out", 32'(spike_out), 0);
        check("reset valid", 32'(spike_valid), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        check("start under reset ignored", 32'(busy), 0);
        tick();
        check("still idle", 32'(busy), 0);

`ifdef SPIKE_ENC_LFSR_EN
        lfsr_frame(8'd255, 0);
        for (int l = 0; l < NP; l++) begin
            int cnt;
            cnt = 0;
            for (int k = 0; k < 16; k++) cnt += int'(rec[0][k][l]);
            check($sformatf("lfsr lane%0d count>=15", l), 32'(cnt >= 15), 1);
        end
        lfsr_frame(8'd255, 1);
        for (int k = 0; k < 16; k++)
            check($sformatf("lfsr repeat step%0d", k + 1), 32'(rec[1][k]), 32'(rec[0][k]));
        lfsr_frame(8'd0, 1);
        for (int k = 0; k < 16; k++)
            check($sformatf("lfsr zero step%0d", k + 1), 32'(rec[1][k]), 0);
`else
        for (int i = 0; i < 7; i++) run_frame(i);

        // Backpressure: stall three cycles on the second vector, nothing may move or be lost.
        begin
            int count;
            int cyc;
            launch(8'd128, 8'd128, 4);
            tick();
            check("bp step1", 32'(spike_out), 32'h0000);
            tick();
            spike_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
                check($sformatf("bp stall%0d valid", s), 32'(spike_valid), 1);
                check($sformatf("bp stall%0d spikes", s), 32'(spike_out), 32'hFFFF);
                tick();
            end
            spike_ready = 1'b1;
            count = 1;
            cyc = 0;
            while (!done && cyc < 20) begin
                if (spike_valid) begin
                    check($sformatf("bp vec%0d", count + 1), 32'(spike_out),
                          32'(frames[0].exp[count]));
                    count++;
                end
                tick();
                cyc++;
            end
            check("bp vector count", 32'(count), 4);
            check("bp done seen", 32'(done), 1);
            tick();
            check("bp idle", 32'(busy), 0);
        end

        // Reset in step 3 of 8, then a fresh frame must start from a cleared accumulator.
        launch(8'd255, 8'd0, 8);
        tick();
        tick();
        tick();
        check("midrst step3 spikes", 32'(spike_out), 32'h0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst spike_out", 32'(spike_out), 0);
        check("midrst valid", 32'(spike_valid), 0);
        check("midrst busy", 32'(busy), 0);
        check("midrst done", 32'(done), 0);
        run_frame(1);
        run_frame(3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
